// File: rtl/mdu_seq.sv
// Sequential multiply/divide unit: shift-add multiply, restoring divide, MTHI/MTLO,
// owns HI/LO and stalls the PC until a multi-cycle result is committed.
module mdu_seq #(
    parameter int WIDTH    = 32,
    parameter int MUL_STEP = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       mduc,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             pc_ena
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] K_MUL   = CNT_W'(WIDTH / MUL_STEP);
    localparam logic [CNT_W-1:0] K_DIV   = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t state_r, state_nxt_s;

    logic [2*WIDTH-1:0]    acc_r;
    logic [WIDTH:0]        rem_r;
    logic [WIDTH-1:0]      mag_r;
    logic [WIDTH-1:0]      a_r;
    logic                  sa_r, sb_r, div_r;
    logic [CNT_W-1:0]      cnt_r;
    logic [WIDTH-1:0]      hi_r, lo_r;
    logic                  busy_r, done_r;

    logic                  op_mul_s, op_div_s, op_md_s, op_signed_s, accept_s;
    logic                  a_neg_s, b_neg_s;
    logic [WIDTH-1:0]      a_mag_s, b_mag_s;
    logic [WIDTH+MUL_STEP-1:0] mcand_ext_s, psum_s, upper_s;
    logic [2*WIDTH-1:0]    mul_acc_nxt_s, div_acc_nxt_s, prod_s;
    logic [WIDTH+1:0]      div_trial_s, div_diff_s;
    logic [WIDTH:0]        rem_nxt_s;
    logic                  quo_bit_s;
    logic [WIDTH-1:0]      quo_s, rem_s, fix_hi_s, fix_lo_s;

    assign hi   = hi_r;
    assign lo   = lo_r;
    assign busy = busy_r;
    assign done = done_r;

    // Opcode decode and operand magnitude/sign extraction
    always_comb begin
        op_mul_s    = (mduc == 3'b001) || (mduc == 3'b010);
        op_div_s    = (mduc == 3'b011) || (mduc == 3'b100);
        op_md_s     = op_mul_s || op_div_s;
        op_signed_s = (mduc == 3'b001) || (mduc == 3'b011);
        accept_s    = (state_r == S_IDLE) && start && !cancel;
        a_neg_s     = op_signed_s && a[WIDTH-1];
        b_neg_s     = op_signed_s && b[WIDTH-1];
        a_mag_s     = a_neg_s ? -a : a;
        b_mag_s     = b_neg_s ? -b : b;
    end

    // Next-state logic; cancel aborts only the multi-cycle states
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (accept_s && op_md_s) begin
                    state_nxt_s = S_ITER;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_ITER: begin
                if (cancel) begin
                    state_nxt_s = S_IDLE;
                end else if (cnt_r == CNT_ONE) begin
                    state_nxt_s = S_FIX;
                end else begin
                    state_nxt_s = S_ITER;
                end
            end
            S_FIX: begin
                if (cancel) begin
                    state_nxt_s = S_IDLE;
                end else begin
                    state_nxt_s = S_DONE;
                end
            end
            S_DONE:  state_nxt_s = S_IDLE;
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // PC write enable: stall from acceptance through FIX
    always_comb begin
        pc_ena = 1'b1;
        if (!rst) begin
            pc_ena = 1'b1;
        end else if ((state_r == S_ITER) || (state_r == S_FIX)) begin
            pc_ena = 1'b0;
        end else if (accept_s && op_md_s) begin
            pc_ena = 1'b0;
        end else begin
            pc_ena = 1'b1;
        end
    end

    // Iteration datapath: MUL_STEP partial products or one restoring divide step
    always_comb begin
        mcand_ext_s = {{MUL_STEP{1'b0}}, mag_r};
        psum_s      = {(WIDTH+MUL_STEP){1'b0}};
        for (int j = 0; j < MUL_STEP; j++) begin
            psum_s = psum_s + (acc_r[j] ? (mcand_ext_s << j) : {(WIDTH+MUL_STEP){1'b0}});
        end
        upper_s       = {{MUL_STEP{1'b0}}, acc_r[2*WIDTH-1:WIDTH]} + psum_s;
        mul_acc_nxt_s = {upper_s, acc_r[WIDTH-1:MUL_STEP]};

        // The trial remainder carries an extra bit so an all-ones dividend cannot overflow
        div_trial_s = {rem_r, acc_r[WIDTH-1]};
        div_diff_s  = div_trial_s - {2'b00, mag_r};
        if (!div_diff_s[WIDTH+1]) begin
            rem_nxt_s = div_diff_s[WIDTH:0];
            quo_bit_s = 1'b1;
        end else begin
            rem_nxt_s = div_trial_s[WIDTH:0];
            quo_bit_s = 1'b0;
        end
        div_acc_nxt_s = {acc_r[2*WIDTH-1:WIDTH], acc_r[WIDTH-2:0], quo_bit_s};
    end

    // Sign fix-up and divide-by-zero override for the committed result
    always_comb begin
        prod_s = (sa_r ^ sb_r) ? -acc_r : acc_r;
        quo_s  = (sa_r ^ sb_r) ? -acc_r[WIDTH-1:0] : acc_r[WIDTH-1:0];
        rem_s  = sa_r ? -rem_r[WIDTH-1:0] : rem_r[WIDTH-1:0];
        if (div_r) begin
            if (mag_r == {WIDTH{1'b0}}) begin
                fix_hi_s = a_r;
                fix_lo_s = {WIDTH{1'b1}};
            end else begin
                fix_hi_s = rem_s;
                fix_lo_s = quo_s;
            end
        end else begin
            fix_hi_s = prod_s[2*WIDTH-1:WIDTH];
            fix_lo_s = prod_s[WIDTH-1:0];
        end
    end

    // State, busy and done registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= S_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= (state_nxt_s == S_ITER) || (state_nxt_s == S_FIX);
            done_r  <= (state_nxt_s == S_DONE);
        end
    end

    // Operand latch, iteration registers and HI/LO
    always_ff @(posedge clk) begin
        if (!rst) begin
            acc_r <= {(2*WIDTH){1'b0}};
            rem_r <= {(WIDTH+1){1'b0}};
            mag_r <= {WIDTH{1'b0}};
            a_r   <= {WIDTH{1'b0}};
            sa_r  <= 1'b0;
            sb_r  <= 1'b0;
            div_r <= 1'b0;
            cnt_r <= {CNT_W{1'b0}};
            hi_r  <= {WIDTH{1'b0}};
            lo_r  <= {WIDTH{1'b0}};
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (accept_s && op_md_s) begin
                        acc_r <= {{WIDTH{1'b0}}, (op_div_s ? a_mag_s : b_mag_s)};
                        mag_r <= op_div_s ? b_mag_s : a_mag_s;
                        rem_r <= {(WIDTH+1){1'b0}};
                        a_r   <= a;
                        sa_r  <= a_neg_s;
                        sb_r  <= b_neg_s;
                        div_r <= op_div_s;
                        cnt_r <= op_div_s ? K_DIV : K_MUL;
                    end else if (accept_s && (mduc == 3'b101)) begin
                        hi_r <= a;
                    end else if (accept_s && (mduc == 3'b110)) begin
                        lo_r <= a;
                    end
                end
                S_ITER: begin
                    if (!cancel) begin
                        cnt_r <= cnt_r - CNT_ONE;
                        if (div_r) begin
                            acc_r <= div_acc_nxt_s;
                            rem_r <= rem_nxt_s;
                        end else begin
                            acc_r <= mul_acc_nxt_s;
                        end
                    end
                end
                S_FIX: begin
                    if (!cancel) begin
                        hi_r <= fix_hi_s;
                        lo_r <= fix_lo_s;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_seq.sv
// Directed bench for mdu_seq: a MUL_STEP=1 and a MUL_STEP=4 instance, results
// checked against a behavioural model through an expected-result queue.
module tb_mdu_seq;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst, start, cancel, start4, cancel4;
    logic [2:0]   mduc, mduc4;
    logic [W-1:0] a, b, a4, b4;
    logic [W-1:0] hi, lo, hi4, lo4;
    logic         busy, done, pc_ena, busy4, done4, pc_ena4;

    int           n_vec  = 0;
    int           n_miss = 0;
    logic [63:0]  sb_q[$];
    logic [63:0]  last_exp;
    int           n_done;

    always #5 clk = ~clk;

    mdu_seq #(.WIDTH(W), .MUL_STEP(1)) dut1 (
        .clk(clk), .rst(rst), .start(start), .mduc(mduc), .a(a), .b(b), .cancel(cancel),
        .hi(hi), .lo(lo), .busy(busy), .done(done), .pc_ena(pc_ena)
    );

    mdu_seq #(.WIDTH(W), .MUL_STEP(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .mduc(mduc4), .a(a4), .b(b4), .cancel(cancel4),
        .hi(hi4), .lo(lo4), .busy(busy4), .done(done4), .pc_ena(pc_ena4)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference result {hi, lo} for a mul/div op
    function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, q, r;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (op)
            3'b001: return 64'(sx * sy);
            3'b010: return {32'h0, x} * {32'h0, y};
            3'b011: begin
                if (y == 32'h0) return {x, 32'hFFFF_FFFF};
                q = sx / sy;
                r = sx % sy;
                return {r[31:0], q[31:0]};
            end
            3'b100: begin
                if (y == 32'h0) return {x, 32'hFFFF_FFFF};
                return {x % y, x / y};
            end
            default: return 64'h0;
        endcase
    endfunction

    // Issue one mul/div on the chosen instance, hold start through the stall, check result
    task automatic run_op(input bit d4, input logic [2:0] op, input logic [31:0] av,
                          input logic [31:0] bv, input int exp_stall, input string tag);
        int stall;
        bit seen;
        sb_q.push_back(model(op, av, bv));
        if (d4) begin
            start4 = 1'b1; mduc4 = op; a4 = av; b4 = bv;
        end else begin
            start = 1'b1; mduc = op; a = av; b = bv;
        end
        stall = 0;
        seen  = 1'b0;
        for (int c = 0; c < 60 && !seen; c++) begin
            #1;
            if (c == 0) chk({tag, "_prev_done"}, 64'(d4 ? done4 : done), 64'd0);
            if (c == 1) begin
                chk({tag, "_busy"}, 64'(d4 ? busy4 : busy), 64'd1);
                if (d4) begin a4 = ~av; b4 = ~bv; end
                else begin a = ~av; b = ~bv; end
            end
            if ((d4 ? done4 : done) === 1'b1) begin
                seen = 1'b1;
            end else begin
                if ((d4 ? pc_ena4 : pc_ena) === 1'b0) stall++;
                @(negedge clk);
            end
        end
        last_exp = sb_q.pop_front();
        chk({tag, "_done"}, 64'(seen), 64'd1);
        chk({tag, "_pc_ena"}, 64'(d4 ? pc_ena4 : pc_ena), 64'd1);
        chk({tag, "_result"}, d4 ? {hi4, lo4} : {hi, lo}, last_exp);
        chk({tag, "_stall"}, 64'(stall), 64'(exp_stall));
        @(negedge clk);
        start = 1'b0; start4 = 1'b0; mduc = 3'b000; mduc4 = 3'b000;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; start = 1'b0; cancel = 1'b0; mduc = 3'b000; a = 32'h0; b = 32'h0;
        start4 = 1'b0; cancel4 = 1'b0; mduc4 = 3'b000; a4 = 32'h0; b4 = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        chk("rst_hilo", {hi, lo}, 64'h0);
        chk("rst_busy_done", {62'h0, busy, done}, 64'h0);
        chk("rst_pc_ena", 64'(pc_ena), 64'd1);
        rst = 1'b1;
        @(negedge clk);

        // MTHI/MTLO: no stall, value visible the next cycle
        start = 1'b1; mduc = 3'b101; a = 32'h1234_5678;
        #1 chk("mthi_nostall", 64'(pc_ena), 64'd1);
        @(negedge clk);
        mduc = 3'b110; a = 32'h9ABC_DEF0;
        #1 chk("mthi_hi", 64'(hi), 64'h1234_5678);
        chk("mtlo_nostall", 64'(pc_ena), 64'd1);
        @(negedge clk);
        start = 1'b0; mduc = 3'b000;
        #1 chk("mtlo_lo", 64'(lo), 64'h9ABC_DEF0);
        chk("mt_no_busy_done", {62'h0, busy, done}, 64'h0);
        @(negedge clk);

        // Reset in the middle of a MULT with start still high
        start = 1'b1; mduc = 3'b001; a = 32'h3; b = 32'h5;
        repeat (4) @(negedge clk);
        #1 chk("mid_busy", 64'(busy), 64'd1);
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("midrst_hilo", {hi, lo}, 64'h0);
        chk("midrst_busy_done", {62'h0, busy, done}, 64'h0);
        chk("midrst_pc_ena", 64'(pc_ena), 64'd1);
        start = 1'b0; mduc = 3'b000; rst = 1'b1;
        @(negedge clk);

        run_op(1'b0, 3'b001, 32'hFFFF_FFFD, 32'h0000_0005, 34, "mult_neg");
        run_op(1'b0, 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, "multu_s1");
        run_op(1'b1, 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 10, "multu_s4");
        run_op(1'b1, 3'b001, 32'hFFFF_FFFD, 32'h0000_0005, 10, "mult_s4");
        run_op(1'b0, 3'b011, 32'hFFFF_FFF9, 32'h0000_0002, 34, "div_neg");
        run_op(1'b0, 3'b011, 32'h8000_0000, 32'hFFFF_FFFF, 34, "div_ovf");
        run_op(1'b0, 3'b100, 32'h0000_0007, 32'h0000_0000, 34, "divu_zero");
        run_op(1'b0, 3'b011, 32'hFFFF_FFF9, 32'h0000_0000, 34, "div_zero_s");
        run_op(1'b0, 3'b001, 32'h1234_5678, 32'h8765_4321, 34, "mult_mix");
        run_op(1'b0, 3'b100, 32'hFFFF_FFFF, 32'h0000_0003, 34, "divu_big");

        // Cancel in IDLE suppresses MTLO and mul acceptance
        start = 1'b1; mduc = 3'b110; a = 32'hDEAD_BEEF; cancel = 1'b1;
        #1 chk("idle_cancel_pc", 64'(pc_ena), 64'd1);
        @(negedge clk);
        mduc = 3'b001;
        #1 chk("idle_cancel_lo", 64'(lo), 64'(last_exp[31:0]));
        chk("idle_cancel_mult_pc", 64'(pc_ena), 64'd1);
        @(negedge clk);
        start = 1'b0; cancel = 1'b0; mduc = 3'b000;
        #1 chk("idle_cancel_noaccept", 64'(busy), 64'd0);
        @(negedge clk);

        // Prime HI, then cancel a MULT in its 5th ITER cycle
        start = 1'b1; mduc = 3'b101; a = 32'h1234_5678;
        @(negedge clk);
        mduc = 3'b001; a = 32'h3; b = 32'h5;
        #1 chk("prime_hi", 64'(hi), 64'h1234_5678);
        repeat (5) @(negedge clk);
        cancel = 1'b1;
        #1 chk("cancel_cycle_pc", 64'(pc_ena), 64'd0);
        @(negedge clk);
        cancel = 1'b0; start = 1'b0; mduc = 3'b000;
        #1;
        chk("cancel_idle", {62'h0, busy, done}, 64'h0);
        chk("cancel_hi", 64'(hi), 64'h1234_5678);
        chk("cancel_pc", 64'(pc_ena), 64'd1);
        n_done = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk); #1;
            if (done === 1'b1) n_done++;
        end
        chk("cancel_no_done", 64'(n_done), 64'd0);
        @(negedge clk);
        run_op(1'b0, 3'b100, 32'd100, 32'd7, 34, "divu_after_cancel");
        run_op(1'b0, 3'b011, 32'd100, 32'hFFFF_FFF9, 34, "div_back2back");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
